// File: rtl/bus_driver_arb_pkg.sv
// Shared state encodings and the index-width helper for the bus driver arbiter.
package bus_driver_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  // Width needed to index n items, never less than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_driver_arb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo NUM_SRC.
module bus_driver_arb_rr_arbiter
  import bus_driver_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = idxWidth(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] pick,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  localparam logic [IDX_W:0] NUM_EXT = (IDX_W+1)'(NUM_SRC);

  logic [2*NUM_SRC-1:0] reqDbl;
  logic [NUM_SRC-1:0]   reqRot;
  logic [IDX_W-1:0]     offset;
  logic [IDX_W:0]       sum;

  assign reqDbl = {req, req} >> ptr;
  assign reqRot = reqDbl[NUM_SRC-1:0];

  // Scan from the far end so the smallest offset from ptr wins.
  always_comb begin
    offset = '0;
    any    = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (reqRot[k]) begin
        offset = IDX_W'(k);
        any    = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= NUM_EXT) sum = sum - NUM_EXT;
    idx = sum[IDX_W-1:0];
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_pick
      assign pick[gi] = any && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/bus_driver_arb.sv
// Round-robin tri-state bus driver with registered data stage and dead turnaround cycles.
// Optional bus-hold keeper on bus_y: define BUS_DRIVER_ARB_BUSHOLD_EN.
module bus_driver_arb
  import bus_driver_arb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUM_SRC    = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 8
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic [NUM_SRC-1:0]           req,
  input  logic [NUM_SRC*WIDTH-1:0]     data,
  output logic [NUM_SRC-1:0]           gnt,
  output logic [idxWidth(NUM_SRC)-1:0] owner,
  output logic                         bus_oe_n,
  output wire  [WIDTH-1:0]             bus_y,
  output logic                         busy
);

  localparam int IDX_W  = idxWidth(NUM_SRC);
  localparam int HOLD_W = idxWidth(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SRC - 1);
  localparam logic [1:0]        TURN_LAST = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;

  logic [1:0]         stateReg, stateNext;
  logic [IDX_W-1:0]   ptrReg, ptrNext;
  logic [IDX_W-1:0]   ownerReg, ownerNext;
  logic [HOLD_W-1:0]  holdReg, holdNext;
  logic [1:0]         turnReg, turnNext;
  logic [WIDTH-1:0]   dataReg, dataNext;
  logic [NUM_SRC-1:0] gntReg, gntNext;

  logic [NUM_SRC-1:0] pick;
  logic [IDX_W-1:0]   pickIdx;
  logic               pickAny;
  logic               othersReq;
  logic               relDrive;

  bus_driver_arb_rr_arbiter #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) uArb (
    .req (req),
    .ptr (ptrReg),
    .pick(pick),
    .idx (pickIdx),
    .any (pickAny)
  );

  // Fairness cut only fires when someone else is actually waiting.
  assign othersReq = |(req & ~gntReg);
  assign relDrive  = !req[ownerReg] ||
                     ((MAX_HOLD != 0) && (holdReg == HOLD_LAST) && othersReq);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stateReg <= ST_IDLE;
      ptrReg   <= '0;
      ownerReg <= '0;
      holdReg  <= '0;
      turnReg  <= '0;
      dataReg  <= '0;
      gntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      ptrReg   <= ptrNext;
      ownerReg <= ownerNext;
      holdReg  <= holdNext;
      turnReg  <= turnNext;
      dataReg  <= dataNext;
      gntReg   <= gntNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    ptrNext   = ptrReg;
    ownerNext = ownerReg;
    holdNext  = holdReg;
    turnNext  = turnReg;
    dataNext  = dataReg;
    gntNext   = gntReg;
    case (stateReg)
      ST_IDLE: begin
        if (pickAny) begin
          stateNext = ST_DRIVE;
          ownerNext = pickIdx;
          gntNext   = pick;
          dataNext  = data[int'(pickIdx)*WIDTH +: WIDTH];
          holdNext  = '0;
        end
      end
      ST_DRIVE: begin
        // Data sampled on the release edge is dropped so the keeper sees the last driven word.
        if (relDrive) begin
          gntNext   = '0;
          holdNext  = '0;
          turnNext  = '0;
          ptrNext   = (ownerReg == LAST_IDX) ? '0 : ownerReg + 1'b1;
          stateNext = (TURNAROUND == 0) ? ST_IDLE : ST_TURN;
        end else begin
          dataNext = data[int'(ownerReg)*WIDTH +: WIDTH];
          if (holdReg != '1) holdNext = holdReg + 1'b1;
        end
      end
      ST_TURN: begin
        if (turnReg == TURN_LAST) stateNext = ST_IDLE;
        else                      turnNext  = turnReg + 1'b1;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt      = gntReg;
    owner    = ownerReg;
    bus_oe_n = (stateReg != ST_DRIVE);
    busy     = (stateReg != ST_IDLE);
  end

`ifdef BUS_DRIVER_ARB_BUSHOLD_EN
  assign (strong0, strong1) bus_y = bus_oe_n ? {WIDTH{1'bz}} : dataReg;
  assign (weak0, weak1)     bus_y = bus_oe_n ? dataReg : {WIDTH{1'bz}};
`else
  assign bus_y = bus_oe_n ? {WIDTH{1'bz}} : dataReg;
`endif

endmodule
